key_indicator_drive: RTL and testbench
======================================

Name: key_indicator_drive

Overview:
- Output-side companion to the keys debounce block: takes per-key single-cycle press events and drives active-low indicators (LED/buzzer) for a fixed on-time.
- Each channel then enforces a minimum off-gap before it can turn on again.
- Each channel buffers at most one press that arrives while it is busy; any further presses are dropped and flagged.
- Sits between the debounce block's pulse outputs and the board indicator pins.

Parameters:
- N, 1: number of channels.
- ON_NUM, 240000: on-time in clk cycles. Must be ≥ 1.
- GAP_NUM, 120000: minimum off-gap in clk cycles. Must be ≥ 1.
- WIDTH, 18: per-channel counter width. Must satisfy 2^WIDTH > max(ON_NUM, GAP_NUM).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- pulse_in  input  N  press events, active-high, nominally one clk wide per event. Level-high for k cycles = k events.
- ind_n  output  N  indicator drive, active-low. Low = indicator on.
- busy  output  N  channel not in IDLE.
- drop  output  N  one-cycle high when a press on that channel is discarded.

Behaviour:
- Reset (async, rst=1):
  - All channels go to IDLE, counters = 0, pending = 0.
  - ind_n = all 1s, busy = 0, drop = 0.
  - Takes effect immediately mid-operation; no residual on-time after release.
- All outputs are registered.
- Channels are fully independent: identical per-channel FSM, with its own counter of WIDTH bits and a 1-bit pending flag.
- FSM states: IDLE, ON, GAP.
- IDLE:
  - ind_n = 1, busy = 0.
  - pulse_in high at edge k → ON from edge k. ind_n low on the cycle after k (latency 1), counter = 0.
- ON:
  - ind_n = 0, busy = 1.
  - Counter increments each cycle. ind_n stays low for exactly ON_NUM cycles.
  - When counter == ON_NUM-1: go to GAP, counter = 0.
- GAP:
  - ind_n = 1, busy = 1.
  - Lasts exactly GAP_NUM cycles.
  - When counter == GAP_NUM-1: if pending (or a pulse arrives that same cycle), go to ON, counter = 0, pending cleared. Otherwise go to IDLE.
- Press while in ON or GAP:
  - pending = 0 → set pending.
  - pending = 1 → press is discarded; drop pulses high for one cycle.
  - No retrigger or extension of the current on-time.
- Boundary conditions:
  - Press on the last ON cycle → becomes pending.
  - Press on the last GAP cycle with pending = 0 → goes straight to ON; no pending set, no drop.
  - Press on the last GAP cycle with pending = 1 → pending is consumed for the new ON; this press sets pending again. No drop.
- Minimum period between ON starts = ON_NUM + GAP_NUM cycles.
- Counters never wrap: they are compared against ON_NUM-1 / GAP_NUM-1 and cleared on every state change.

Test Plan:
(Bench parameters unless stated otherwise: N=2, ON_NUM=4, GAP_NUM=3, WIDTH=3.)
1. Reset/idle: assert rst for 2 cycles, then release with pulse_in = 0 → ind_n = 2'b11, busy = 0, drop = 0 for 20 cycles.
2. Single press: pulse_in[0] high for 1 cycle at edge 10 → ind_n[0] low during cycles 11–14 and high from 15; busy[0] high during cycles 11–17; channel 1 untouched.
3. Queued press: ch0 pulses at edges 10 and 12 → first on-time in cycles 11–14, gap in cycles 15–17, second on-time in cycles 18–21; drop stays 0.
4. Overflow: ch0 pulses at edges 10, 12, 13 → the pulse at 13 raises drop[0] for 1 cycle (cycle 14); exactly two on-times, as in scenario 3.
5. Gap-edge press: ch1 pulses at edge 10, then again at edge 17 (last GAP cycle) → second on-time in cycles 18–21 with no pending residue; busy[1] falls after cycle 24.
6. Async reset mid-ON: assert rst at cycle 12 while ch0 is in ON → ind_n[0] goes to 1 immediately; after release there is no output until a new pulse arrives.

Source files
------------

// File: rtl/key_indicator_drive.sv
// Per-channel indicator driver: a press lights an active-low indicator for ON_NUM
// cycles, then holds it dark for GAP_NUM cycles, with one press of lookahead.
module key_indicator_chan #(
  parameter int ON_NUM  = 240000,
  parameter int GAP_NUM = 120000,
  parameter int WIDTH   = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pulse,
  output logic o_ind_n,
  output logic o_busy,
  output logic o_drop
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [WIDTH-1:0] ON_LAST  = WIDTH'(ON_NUM - 1);
  localparam logic [WIDTH-1:0] GAP_LAST = WIDTH'(GAP_NUM - 1);

  logic [1:0]       r_state, w_state_nx;
  logic [WIDTH-1:0] r_cnt, w_cnt_nx;
  logic             r_pend, w_pend_nx, w_drop_nx;
  logic             r_ind_n, r_busy, r_drop;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pend_nx  = r_pend;
    w_drop_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_pulse) begin
          w_state_nx = S_ON;
          w_cnt_nx   = '0;
        end
      end
      S_ON: begin
        if (r_cnt == ON_LAST) begin
          w_state_nx = S_GAP;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
        if (i_pulse) begin
          if (r_pend) w_drop_nx = 1'b1;
          else        w_pend_nx = 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nx = '0;
          // Pending press starts the new on-time; a same-cycle press re-arms pending.
          if (r_pend || i_pulse) begin
            w_state_nx = S_ON;
            w_pend_nx  = r_pend & i_pulse;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
          if (i_pulse) begin
            if (r_pend) w_drop_nx = 1'b1;
            else        w_pend_nx = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_pend_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_ind_n <= 1'b1;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pend  <= w_pend_nx;
      r_ind_n <= (w_state_nx != S_ON);
      r_busy  <= (w_state_nx != S_IDLE);
      r_drop  <= w_drop_nx;
    end
  end

  assign o_ind_n = r_ind_n;
  assign o_busy  = r_busy;
  assign o_drop  = r_drop;
endmodule

module key_indicator_drive #(
  parameter int N       = 1,
  parameter int ON_NUM  = 240000,
  parameter int GAP_NUM = 120000,
  parameter int WIDTH   = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pulse_in,
  output logic [N-1:0] ind_n,
  output logic [N-1:0] busy,
  output logic [N-1:0] drop
);
  key_indicator_chan #(
    .ON_NUM (ON_NUM),
    .GAP_NUM(GAP_NUM),
    .WIDTH  (WIDTH)
  ) u_chan [N-1:0] (
    .clk    (clk),
    .rst    (rst),
    .i_pulse(pulse_in),
    .o_ind_n(ind_n),
    .o_busy (busy),
    .o_drop (drop)
  );
endmodule

// File: tb/tb_key_indicator_drive.sv
// Bench for key_indicator_drive: directed scenarios then random presses, checked
// against a start-time based model of each channel's on/gap schedule.
module tb_key_indicator_drive;
  localparam int N = 2, ON = 4, GAP = 3, W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pulse_in = '0;
  logic [N-1:0] ind_n, busy, drop;

  key_indicator_drive #(.N(N), .ON_NUM(ON), .GAP_NUM(GAP), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in),
    .ind_n(ind_n), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, t = 0;
  // Model: a channel is active from its start edge until start+ON+GAP.
  bit m_act [N];
  bit m_pend[N];
  bit m_drop[N];
  int m_start[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_pend[i] = 0; m_drop[i] = 0; m_start[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) begin
      m_drop[i] = 0;
      if (m_act[i] && t == m_start[i] + ON + GAP) begin
        if (m_pend[i]) begin
          m_start[i] = t; m_pend[i] = p[i];
        end else if (p[i]) begin
          m_start[i] = t;
        end else begin
          m_act[i] = 0;
        end
      end else if (m_act[i]) begin
        if (p[i]) begin
          if (m_pend[i]) m_drop[i] = 1;
          else           m_pend[i] = 1;
        end
      end else if (p[i]) begin
        m_act[i] = 1; m_start[i] = t;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic chk_model();
    logic [N-1:0] e_ind, e_busy, e_drop;
    for (int i = 0; i < N; i++) begin
      e_ind[i]  = !(m_act[i] && (t - m_start[i]) < ON);
      e_busy[i] = m_act[i];
      e_drop[i] = m_drop[i];
    end
    chk("ind_n", ind_n, e_ind);
    chk("busy", busy, e_busy);
    chk("drop", drop, e_drop);
  endtask

  task automatic tick(input logic [N-1:0] p);
    pulse_in = p;
    @(posedge clk);
    t++;
    model_edge(p);
    #1;
    chk_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick('0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pulse_in = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ind_n", ind_n, '1);
    chk("rst_busy", busy, '0);
    chk("rst_drop", drop, '0);
    #2 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    // 1: reset then idle
    do_reset();
    idle(20);
    // 2: single press on ch0
    do_reset(); idle(9); tick(2'b01); idle(10);
    // 3: queued press
    do_reset(); idle(9); tick(2'b01); tick(2'b00); tick(2'b01); idle(14);
    // 4: overflow, drop visible one cycle after the third press
    do_reset(); idle(9); tick(2'b01); tick(2'b00); tick(2'b01); tick(2'b01);
    chk("drop_overflow", drop, 2'b01);
    idle(14);
    // 5: press on the last gap cycle of ch1
    do_reset(); idle(9); tick(2'b10); idle(6); tick(2'b10);
    chk("gap_edge_ind", ind_n, 2'b01);
    idle(10);
    // 6: async reset while ch0 is on
    do_reset(); idle(9); tick(2'b01); tick(2'b00);
    #2 rst = 1'b1;
    #1;
    chk("async_ind_n", ind_n, '1);
    chk("async_busy", busy, '0);
    model_reset();
    @(posedge clk); #2 rst = 1'b0;
    idle(12);
    // Random presses with occasional mid-run resets
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] p;
      for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 3) == 0);
      if (k % 200 == 199) begin
        #2 rst = 1'b1;
        #1;
        chk("rand_rst_ind_n", ind_n, '1);
        model_reset();
        @(posedge clk); #2 rst = 1'b0;
      end
      tick(p);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
